// File: rtl/pwm_pkg.sv
// Shared types and control-register bit positions for the PWM core.
// Optional breathe mode is enabled by defining PWM_BREATHE_EN.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;
    localparam int CTRL_BRE = 2;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: tick fires once every pre_s+1 clocks while run is high.
// The divide value is shadowed and only updated when load is asserted.
module pwm_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PRE_W-1:0] presc,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    output logic             tick
);

    logic [PRE_W-1:0] pre_s;
    logic [PRE_W-1:0] pre_cnt;

    assign tick = run && (pre_cnt == pre_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_s   <= '0;
            pre_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            if (load) begin
                pre_s <= presc;
            end
            if (clear) begin
                pre_cnt <= '0;
            end else if (run) begin
                pre_cnt <= (pre_cnt == pre_s) ? '0 : pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_core.sv
// PWM generator fed by the pwm_ip register slave; period/duty/prescaler are
// shadowed and reload only at a period wrap. Define PWM_BREATHE_EN for breathe mode.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int PRE_W        = 16,
    parameter int BREATHE_STEP = 1
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] ctrl_i,
    input  logic [31:0] period_i,
    input  logic [31:0] duty_i,
    input  logic [31:0] presc_i,
    output logic        pwm_o,
    output logic        period_tick_o,
    output logic        busy_o
);

    pwm_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_s;
    logic [CNT_W-1:0] duty_s;
    logic [CNT_W-1:0] duty_next;
    logic             en;
    logic             inv;
    logic             act;
    logic             tick;
    logic             start;
    logic             stop;
    logic             wrap;

    assign en    = ctrl_i[CTRL_EN];
    assign inv   = ctrl_i[CTRL_INV];
    assign act   = cnt < duty_s;
    assign start = (state == IDLE) && en;
    assign stop  = (state == RUN) && !en;
    // Dropping enable on the wrap edge suppresses the wrap entirely.
    assign wrap  = (state == RUN) && en && tick && (cnt == per_s);

    pwm_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .presc (presc_i[PRE_W-1:0]),
        .load  (start || wrap),
        .clear (start || stop),
        .run   (state == RUN),
        .tick  (tick)
    );

`ifdef PWM_BREATHE_EN
    logic           dir_up;
    logic           dir_next;
    logic [CNT_W:0] step_w;
    logic [CNT_W:0] up_sum;

    assign step_w = (CNT_W+1)'(BREATHE_STEP);
    assign up_sum = {1'b0, duty_s} + step_w;

    // Extra top bit on the sums keeps the ramp from wrapping past the limits.
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        duty_next = duty_i[CNT_W-1:0];
        dir_next  = dir_up;
        if (ctrl_i[CTRL_BRE]) begin
            if (dir_up) begin
                if (up_sum >= {1'b0, period_i[CNT_W-1:0]}) begin
                    duty_next = period_i[CNT_W-1:0];
                    dir_next  = 1'b0;
                end else begin
                    duty_next = up_sum[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, duty_s} <= step_w) begin
                    duty_next = '0;
                    dir_next  = 1'b1;
                end else begin
                    duty_next = duty_s - step_w[CNT_W-1:0];
                end
            end
        end
    end

    logic unused;
    assign unused = ^{ctrl_i[31:3], period_i[31:CNT_W], duty_i[31:CNT_W], presc_i[31:PRE_W]};
`else
    assign duty_next = duty_i[CNT_W-1:0];

    logic unused;
    assign unused = (^{ctrl_i[31:2], period_i[31:CNT_W], duty_i[31:CNT_W], presc_i[31:PRE_W]})
                    ^ (BREATHE_STEP != 0);
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            per_s         <= '0;
            duty_s        <= '0;
            pwm_o         <= 1'b0;
            period_tick_o <= 1'b0;
            busy_o        <= 1'b0;
`ifdef PWM_BREATHE_EN
            dir_up        <= 1'b1;
`endif
        end else begin
            period_tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    pwm_o <= inv;
                    if (en) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        per_s  <= period_i[CNT_W-1:0];
                        duty_s <= duty_i[CNT_W-1:0];
`ifdef PWM_BREATHE_EN
                        dir_up <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    pwm_o <= act ^ inv;
                    if (!en) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else if (tick) begin
                        if (cnt == per_s) begin
                            cnt           <= '0;
                            period_tick_o <= 1'b1;
                            per_s         <= period_i[CNT_W-1:0];
                            duty_s        <= duty_next;
`ifdef PWM_BREATHE_EN
                            dir_up        <= dir_next;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: directed scenarios push expected samples and
// per-period high/length counts; a negedge monitor pops and compares them.
module tb_pwm_core;

    logic        ACLK;
    logic        ARESETN;
    logic [31:0] ctrl_i;
    logic [31:0] period_i;
    logic [31:0] duty_i;
    logic [31:0] presc_i;
    logic        pwm_o;
    logic        period_tick_o;
    logic        busy_o;

    typedef struct {
        string name;
        logic  pwm;
        logic  tick;
        logic  busy;
    } samp_t;

    typedef struct {
        string name;
        int    high;
        int    len;
    } per_t;

    samp_t samp_q[$];
    per_t  per_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    pwm_core dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ctrl_i        (ctrl_i),
        .period_i      (period_i),
        .duty_i        (duty_i),
        .presc_i       (presc_i),
        .pwm_o         (pwm_o),
        .period_tick_o (period_tick_o),
        .busy_o        (busy_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic expect_now(input string name, input logic pwm, input logic tick, input logic busy);
        samp_q.push_back('{name, pwm, tick, busy});
    endtask

    task automatic push_period(input string name, input int high, input int len);
        per_q.push_back('{name, high, len});
    endtask

    // Runs until at most 'keep' period expectations remain outstanding.
    task automatic wait_periods(input int keep, input int budget);
        int n = 0;
        while (per_q.size() > keep && n < budget) begin
            cyc();
            n++;
        end
        if (per_q.size() > keep) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: %0d periods still expected after %0d cycles", per_q.size(), budget);
            per_q.delete();
        end
    endtask

    task automatic start_run(input logic [31:0] c, input logic [31:0] p,
                             input logic [31:0] d, input logic [31:0] s);
        ctrl_i   = c;
        period_i = p;
        duty_i   = d;
        presc_i  = s;
        cyc();
    endtask

    task automatic stop_run(input logic inv);
        ctrl_i = inv ? 32'h2 : 32'h0;
        cyc();
        cyc();
        expect_now("idle_level", inv, 1'b0, 1'b0);
        cyc();
    endtask

    // A period runs from one period_tick_o sample to the next; the tick sample
    // itself still shows the last count of the closing period.
    initial begin : monitor
        samp_t s;
        per_t  p;
        bit    armed;
        int    run_high;
        int    run_len;
        armed    = 1'b0;
        run_high = 0;
        run_len  = 0;
        forever begin
            @(negedge ACLK);
            if (samp_q.size() > 0) begin
                s = samp_q.pop_front();
                check({s.name, ".pwm"},  int'(pwm_o),         int'(s.pwm));
                check({s.name, ".tick"}, int'(period_tick_o), int'(s.tick));
                check({s.name, ".busy"}, int'(busy_o),        int'(s.busy));
            end
            if (!ARESETN || !busy_o) begin
                armed    = 1'b0;
                run_high = 0;
                run_len  = 0;
            end else begin
                if (armed) begin
                    run_len++;
                    run_high += int'(pwm_o);
                end
                if (period_tick_o) begin
                    if (armed) begin
                        if (per_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL unexpected_tick: period_tick_o with no period expected (t=%0t)", $time);
                        end else begin
                            p = per_q.pop_front();
                            check({p.name, ".high"}, run_high, p.high);
                            check({p.name, ".len"},  run_len,  p.len);
                        end
                    end
                    armed    = 1'b1;
                    run_high = 0;
                    run_len  = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        ARESETN  = 1'b0;
        ctrl_i   = '0;
        period_i = '0;
        duty_i   = '0;
        presc_i  = '0;
        cyc();
        expect_now("reset", 1'b0, 1'b0, 1'b0);
        cyc();
        ARESETN = 1'b1;
        cyc();
        cyc();

        // Basic 3/10 waveform and start latency.
        start_run(32'h1, 32'd9, 32'd3, 32'd0);
        expect_now("start", 1'b0, 1'b0, 1'b1);
        cyc();
        expect_now("first_high", 1'b1, 1'b0, 1'b1);
        cyc();
        cyc();
        expect_now("third_high", 1'b1, 1'b0, 1'b1);
        cyc();
        expect_now("fourth_low", 1'b0, 1'b0, 1'b1);
        repeat (6) cyc();
        expect_now("first_tick", 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_period("d3", 3, 10);
        wait_periods(0, 100);

        // Duty write at cnt=4 only lands at the next wrap.
        repeat (3) cyc();
        duty_i = 32'd7;
        push_period("d3_keep", 3, 10);
        push_period("d7", 7, 10);
        push_period("d7", 7, 10);
        wait_periods(0, 100);

        // Enable cleared at cnt=5: immediate stop, no tick.
        repeat (4) cyc();
        ctrl_i = 32'h0;
        cyc();
        expect_now("stop_edge", 1'b1, 1'b0, 1'b0);
        cyc();
        expect_now("stop_idle", 1'b0, 1'b0, 1'b0);
        cyc();

        // duty=0 is constantly inactive.
        start_run(32'h1, 32'd9, 32'd0, 32'd0);
        expect_now("d0_start", 1'b0, 1'b0, 1'b1);
        cyc();
        expect_now("d0_first", 1'b0, 1'b0, 1'b1);
        push_period("d0", 0, 10);
        push_period("d0", 0, 10);
        wait_periods(0, 100);
        stop_run(1'b0);

        // duty>period is constantly active; upper input bits are discarded.
        start_run(32'h1, 32'hABCD_0009, 32'h0001_000C, 32'd0);
        cyc();
        expect_now("d12_first", 1'b1, 1'b0, 1'b1);
        push_period("d12", 10, 10);
        push_period("d12", 10, 10);
        wait_periods(0, 100);
        stop_run(1'b0);

        // Inverted polarity, including the idle level.
        start_run(32'h3, 32'd9, 32'd3, 32'd0);
        expect_now("inv_start", 1'b1, 1'b0, 1'b1);
        cyc();
        expect_now("inv_first", 1'b0, 1'b0, 1'b1);
        push_period("inv", 7, 10);
        push_period("inv", 7, 10);
        wait_periods(0, 100);
        stop_run(1'b1);
        ctrl_i = 32'h0;
        cyc();
        cyc();

        // Prescaler of 1 doubles the period.
        start_run(32'h1, 32'd9, 32'd5, 32'hFFFF_0001);
        push_period("presc1", 10, 20);
        push_period("presc1", 10, 20);
        wait_periods(0, 200);
        stop_run(1'b0);

        // period=0, duty=1: one-clock periods, constantly active.
        start_run(32'h1, 32'd0, 32'd1, 32'd0);
        cyc();
        expect_now("per0_first", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) push_period("per0", 1, 1);
        wait_periods(1, 50);
        stop_run(1'b0);

        // Asynchronous reset mid-period.
        start_run(32'h1, 32'd9, 32'd7, 32'd0);
        repeat (4) cyc();
        expect_now("pre_reset", 1'b1, 1'b0, 1'b1);
        cyc();
        #1;
        ARESETN = 1'b0;
        ctrl_i  = 32'h0;
        expect_now("reset_async", 1'b0, 1'b0, 1'b0);
        cyc();
        expect_now("reset_hold", 1'b0, 1'b0, 1'b0);
        cyc();
        ARESETN = 1'b1;
        cyc();
        expect_now("after_reset", 1'b0, 1'b0, 1'b0);
        cyc();

`ifdef PWM_BREATHE_EN
        // Breathe: duty 0,1,2,3,2,1,0,1 over successive periods of 4 clocks.
        start_run(32'h5, 32'd3, 32'd0, 32'd0);
        cyc();
        expect_now("bre_first", 1'b0, 1'b0, 1'b1);
        push_period("bre1", 1, 4);
        push_period("bre2", 2, 4);
        push_period("bre3", 3, 4);
        push_period("bre2d", 2, 4);
        push_period("bre1d", 1, 4);
        push_period("bre0", 0, 4);
        push_period("bre1u", 1, 4);
        wait_periods(0, 100);
        stop_run(1'b0);
`endif

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_core.md
# pwm_core

PWM generation core that sits directly downstream of the `pwm_ip` AXI4-Lite register slave. It consumes the four 32-bit slave registers: control, period, duty and prescaler. It produces a single registered PWM output for the board LED. Period and duty are double-buffered, so software writes take effect only at a period boundary and never cause glitches.

## Interface
- `CNT_W`, 16: width of the period/duty counter and compare values.
- `PRE_W`, 16: width of the prescaler counter.
- `BREATHE_STEP`, 1: duty increment per period in breathe mode (only used with the macro).
- `ACLK`  in  1  core clock, same clock as the AXI slave.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `ctrl_i`  in  32  slv_reg0. Bit 0 = enable, bit 1 = invert polarity, bit 2 = breathe mode. Other bits ignored.
- `period_i`  in  32  slv_reg1. Bits [CNT_W-1:0] are used; the counter runs 0..period.
- `duty_i`  in  32  slv_reg2. Bits [CNT_W-1:0] are used; output is active while cnt < duty.
- `presc_i`  in  32  slv_reg3. Bits [PRE_W-1:0] are used; one count tick every presc+1 clocks.
- `pwm_o`  out  1  registered PWM output, polarity applied.
- `period_tick_o`  out  1  one-cycle pulse when the counter wraps.
- `busy_o`  out  1  high while in state RUN.

## Operation
- **FSM states:** IDLE, RUN.
- **IDLE → RUN:** when ctrl_i[0]=1. On that edge:
  - load shadows: per_s←period_i, duty_s←duty_i, pre_s←presc_i;
  - clear cnt and pre_cnt.
- **RUN → IDLE:** when ctrl_i[0]=0. Takes effect on the next edge, with no wait for the period end. On that edge, cnt and pre_cnt are cleared.
- **Prescaler:** pre_cnt counts 0..pre_s. A tick is asserted when pre_cnt==pre_s, and pre_cnt wraps to 0.
- **Counter:** on a tick, cnt increments. When cnt==per_s, cnt wraps to 0 instead.
- **Wrap:** on the wrap edge, period_tick_o pulses and all three shadows reload from the inputs.
- **Compare:** act = (cnt < duty_s).
  - duty_s=0 gives a constant inactive output.
  - duty_s>per_s gives a constant active output (100%).
  - per_s=0 with duty_s≥1 gives a constant active output.
- **Output:** pwm_o ← act XOR ctrl_i[1] in RUN, and ← ctrl_i[1] (inactive level) in IDLE. Polarity follows ctrl_i[1] directly and is not shadowed.
- **Arithmetic:** all compares are unsigned on CNT_W bits. Bits of the inputs above CNT_W/PRE_W are discarded.
- **Simultaneous events:** if enable drops on the wrap edge, IDLE wins: no reload and no period_tick_o. A register write on the wrap edge is captured by that reload.

## Timing
- **Reset:** asynchronous. All state is cleared immediately on ARESETN low: state=IDLE, cnt=0, pre_cnt=0, shadows=0, pwm_o=0, period_tick_o=0, busy_o=0. Reset mid-period aborts with no completion.
- **Start latency:** if enable is sampled high at edge N, then busy_o=1 after N, cnt=0 after N, and pwm_o reflects cnt=0 after edge N+1.
- **Output latency:** pwm_o lags cnt by one clock.
- **Stop latency:** pwm_o is at the inactive level one clock after busy_o falls.
- **Period length:** (per_s+1)·(pre_s+1) clocks exactly, with no gap between periods.

## Configuration
- `PWM_BREATHE_EN` defined:
  - While ctrl_i[2]=1, duty_i is ignored after start.
  - At each wrap, duty_s steps by ±BREATHE_STEP. It ramps up to per_s, then reverses down to 0, then reverses again. It clamps at the limits and never wraps.
  - The direction bit resets to "up" on entry to RUN.
- `PWM_BREATHE_EN` undefined: ctrl_i[2] is ignored and the breathe logic and direction flop are not compiled.

## Structure
- Package `pwm_pkg`:
  - state enum `pwm_state_e` {IDLE, RUN};
  - ctrl bit index constants CTRL_EN=0, CTRL_INV=1, CTRL_BRE=2.
- One sub-module, `pwm_prescaler`: pre_cnt, load and clear inputs, tick output.
- The FSM, shadows, counter and compare stay in `pwm_core`.

## Test plan
- presc=0, period=9, duty=3, enable → pwm_o high 3 of every 10 clocks; period_tick_o every 10 clocks; first high 2 clocks after enable sampled.
- duty=0 → pwm_o constantly 0; duty=12 with period=9 → constantly 1; invert=1 with duty=3 → low 3 / high 7, and 1 when idle.
- Write duty 3→7 at cnt=4 → current period keeps 3 high; next period 7 high.
- presc=1, period=9, duty=5 → 20-clock period, pwm_o high 10 clocks.
- ARESETN low at cnt=5 → pwm_o, busy_o, period_tick_o 0 immediately; enable clear at cnt=5 → busy_o 0 next edge, no tick.
- With `PWM_BREATHE_EN`, period=3, step=1 → duty sequence 0,1,2,3,2,1,0,1 over successive periods.
